// File: rtl/and_result_fifo.sv
// -----------------------------------------------------------------------------
// and_result_fifo
//
// First-word-fall-through buffer for the bitwise-AND result words. It accepts
// one word per clock from a producer that cannot be stalled. It hands the words
// to a consumer in order over a valid/ready handshake. A push that arrives
// while the buffer is full is dropped. Dropped pushes set a sticky flag and
// bump a saturating counter.
//
// Parameters:
//   WIDTH   data word width
//   DEPTH   number of entries (power of two, >= 2)
//   ADDR_W  pointer width, log2(DEPTH)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   push request this cycle
//   in_data    word to store
//   out_valid  head entry present (registered count != 0)
//   out_ready  consumer takes the head entry this cycle
//   out_data   head entry, 0 while empty
//   count      occupancy, 0..DEPTH
//   full       count == DEPTH
//   overflow   sticky, set by the first dropped push
//   drop_cnt   dropped pushes, saturating at 255
// -----------------------------------------------------------------------------
module and_result_fifo #(
   parameter int WIDTH  = 4,
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [WIDTH-1:0]  in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_data,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              overflow,
   output logic [7:0]        drop_cnt
);

   localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count_q;
   logic              overflow_q;
   logic [7:0]        drop_cnt_q;

   logic pop;
   logic push_ok;
   logic drop;

   // Increment that holds at the all-ones value instead of wrapping.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Status comes only from the registered occupancy.
   assign count     = count_q;
   assign full      = (count_q == FULL_CNT);
   assign out_valid = (count_q != '0);
   assign overflow  = overflow_q;
   assign drop_cnt  = drop_cnt_q;

   // A pop frees a slot on the same edge, so a push into a full FIFO is still
   // accepted when the consumer takes the head in that cycle.
   assign pop     = out_valid & out_ready;
   assign push_ok = in_valid & (~full | pop);
   assign drop    = in_valid & full & ~pop;

   // Fall-through read. The result is forced to zero while empty, so a reset
   // never exposes a stale entry.
   assign out_data = out_valid ? mem[rd_ptr] : '0;

   // ---- storage write (array contents are not reset) ----
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= in_data;
      end
   end

   // ---- pointers, occupancy and drop tracking ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= 8'd0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (push_ok && !pop) begin
            count_q <= count_q + CNT_ONE;
         end else if (pop && !push_ok) begin
            count_q <= count_q - CNT_ONE;
         end
         if (drop) begin
            overflow_q <= 1'b1;
            drop_cnt_q <= sat_inc8(drop_cnt_q);
         end
      end
   end

endmodule

// File: tb/tb_and_result_fifo.sv
module tb_and_result_fifo;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [3:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_data;
   logic [2:0] count;
   logic       full;
   logic       overflow;
   logic [7:0] drop_cnt;

   int n_cmp  = 0;
   int n_fail = 0;

   and_result_fifo #(.WIDTH(4), .DEPTH(4), .ADDR_W(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count),
      .full      (full),
      .overflow  (overflow),
      .drop_cnt  (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       iv;
      logic [3:0] din;
      logic       rdy;
      logic [2:0] e_count;
      logic       e_valid;
      logic [3:0] e_data;
      logic       e_full;
      logic       e_ovf;
      logic [7:0] e_drop;
   } vec_t;

   vec_t vecs[20];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int c, input int v, input int d,
                          input int f, input int o, input int dc);
      chk({tag, ".count"},     int'(count),     c);
      chk({tag, ".out_valid"}, int'(out_valid), v);
      chk({tag, ".out_data"},  int'(out_data),  d);
      chk({tag, ".full"},      int'(full),      f);
      chk({tag, ".overflow"},  int'(overflow),  o);
      chk({tag, ".drop_cnt"},  int'(drop_cnt),  dc);
   endtask

   // One clock; inputs stay put until 1 time unit after the edge, then the
   // post-edge outputs are stable for checking.
   task automatic step(input logic iv, input logic [3:0] d, input logic rdy);
      in_valid  = iv;
      in_data   = d;
      out_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("reset", 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 4'h0;
      out_ready = 1'b0;

      // iv, din, rdy | count, valid, data, full, ovf, drop
      // ordering
      vecs[0]  = '{1'b1, 4'hA, 1'b0, 3'd1, 1'b1, 4'hA, 1'b0, 1'b0, 8'd0};
      vecs[1]  = '{1'b1, 4'h5, 1'b0, 3'd2, 1'b1, 4'hA, 1'b0, 1'b0, 8'd0};
      vecs[2]  = '{1'b1, 4'h3, 1'b0, 3'd3, 1'b1, 4'hA, 1'b0, 1'b0, 8'd0};
      vecs[3]  = '{1'b0, 4'h0, 1'b1, 3'd2, 1'b1, 4'h5, 1'b0, 1'b0, 8'd0};
      vecs[4]  = '{1'b0, 4'h0, 1'b1, 3'd1, 1'b1, 4'h3, 1'b0, 1'b0, 8'd0};
      vecs[5]  = '{1'b0, 4'h0, 1'b1, 3'd0, 1'b0, 4'h0, 1'b0, 1'b0, 8'd0};
      vecs[6]  = '{1'b0, 4'h0, 1'b1, 3'd0, 1'b0, 4'h0, 1'b0, 1'b0, 8'd0};
      // fill and overflow
      vecs[7]  = '{1'b1, 4'h1, 1'b0, 3'd1, 1'b1, 4'h1, 1'b0, 1'b0, 8'd0};
      vecs[8]  = '{1'b1, 4'h2, 1'b0, 3'd2, 1'b1, 4'h1, 1'b0, 1'b0, 8'd0};
      vecs[9]  = '{1'b1, 4'h3, 1'b0, 3'd3, 1'b1, 4'h1, 1'b0, 1'b0, 8'd0};
      vecs[10] = '{1'b1, 4'h4, 1'b0, 3'd4, 1'b1, 4'h1, 1'b1, 1'b0, 8'd0};
      vecs[11] = '{1'b1, 4'hF, 1'b0, 3'd4, 1'b1, 4'h1, 1'b1, 1'b1, 8'd1};
      // full with simultaneous push and pop, then drain 2,3,4,9
      vecs[12] = '{1'b1, 4'h9, 1'b1, 3'd4, 1'b1, 4'h2, 1'b1, 1'b1, 8'd1};
      vecs[13] = '{1'b0, 4'h0, 1'b1, 3'd3, 1'b1, 4'h3, 1'b0, 1'b1, 8'd1};
      vecs[14] = '{1'b0, 4'h0, 1'b1, 3'd2, 1'b1, 4'h4, 1'b0, 1'b1, 8'd1};
      vecs[15] = '{1'b0, 4'h0, 1'b1, 3'd1, 1'b1, 4'h9, 1'b0, 1'b1, 8'd1};
      vecs[16] = '{1'b0, 4'h0, 1'b1, 3'd0, 1'b0, 4'h0, 1'b0, 1'b1, 8'd1};
      // count == 1 with push and pop together
      vecs[17] = '{1'b1, 4'h7, 1'b0, 3'd1, 1'b1, 4'h7, 1'b0, 1'b1, 8'd1};
      vecs[18] = '{1'b1, 4'h8, 1'b1, 3'd1, 1'b1, 4'h8, 1'b0, 1'b1, 8'd1};
      vecs[19] = '{1'b0, 4'h0, 1'b1, 3'd0, 1'b0, 4'h0, 1'b0, 1'b1, 8'd1};

      do_reset();

      for (int i = 0; i < 20; i++) begin
         step(vecs[i].iv, vecs[i].din, vecs[i].rdy);
         chk_all($sformatf("vec%0d", i), int'(vecs[i].e_count), int'(vecs[i].e_valid),
                 int'(vecs[i].e_data), int'(vecs[i].e_full), int'(vecs[i].e_ovf),
                 int'(vecs[i].e_drop));
      end

      // Reset mid-stream with three words buffered and overflow set.
      step(1'b1, 4'hC, 1'b0);
      step(1'b1, 4'hD, 1'b0);
      step(1'b1, 4'hE, 1'b0);
      chk("midrst.pre_count", int'(count), 3);
      in_valid = 1'b0;
      do_reset();
      step(1'b0, 4'h0, 1'b0);
      chk_all("post_rst_idle", 0, 0, 0, 0, 0, 0);

      // Wrap-around streaming with the consumer always ready.
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 4'(i), 1'b1);
         chk($sformatf("wrap%0d.data", i), int'(out_data), i);
         chk($sformatf("wrap%0d.count", i), int'(count), 1);
         chk($sformatf("wrap%0d.drop", i), int'(drop_cnt), 0);
      end
      step(1'b0, 4'h0, 1'b1);
      chk_all("wrap_end", 0, 0, 0, 0, 0, 0);

      // Saturation: fill, then hold pushes against a full FIFO for 300 cycles.
      step(1'b1, 4'h6, 1'b0);
      step(1'b1, 4'h7, 1'b0);
      step(1'b1, 4'h8, 1'b0);
      step(1'b1, 4'h9, 1'b0);
      chk("sat.full", int'(full), 1);
      for (int i = 0; i < 300; i++) begin
         step(1'b1, 4'h5, 1'b0);
         if (i == 253) chk("sat.drop254", int'(drop_cnt), 254);
         if (i == 254) chk("sat.drop255", int'(drop_cnt), 255);
      end
      chk_all("sat_end", 4, 1, 6, 1, 1, 255);

      // Drain to confirm stored order survived the drops.
      step(1'b0, 4'h0, 1'b1);
      chk("sat.drain1", int'(out_data), 7);
      step(1'b0, 4'h0, 1'b1);
      chk("sat.drain2", int'(out_data), 8);
      step(1'b0, 4'h0, 1'b1);
      chk("sat.drain3", int'(out_data), 9);
      step(1'b0, 4'h0, 1'b1);
      chk_all("sat_drained", 0, 0, 0, 0, 1, 255);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
